// File: rtl/dma_rd_split.sv
// dma_rd_split: breaks one large read request into dma_rd commands that never
// exceed MAX_BURST words and never cross a BOUNDARY-byte address boundary.
module dma_rd_split #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int CONFIG_LEN_WIDTH = 9,
  parameter int XFER_LEN_WIDTH   = 20,
  parameter int MAX_BURST        = 256,
  parameter int BOUNDARY         = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [XFER_LEN_WIDTH-1:0]   req_len,
  output logic                        config_valid,
  input  logic                        config_ready,
  output logic [AXI_ADDR_WIDTH-1:0]   config_addr,
  output logic [CONFIG_LEN_WIDTH-1:0] config_len,
  input  logic                        config_empty,
  output logic                        busy,
  output logic                        done,
  output logic [XFER_LEN_WIDTH-1:0]   cmd_count
);

  localparam int BPW     = AXI_DATA_WIDTH / 8;
  localparam int BPW_LOG = $clog2(BPW);
  localparam int CW      = (AXI_ADDR_WIDTH + 1 > XFER_LEN_WIDTH) ? AXI_ADDR_WIDTH + 1 : XFER_LEN_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t                    state;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [XFER_LEN_WIDTH-1:0] remaining;
  logic                      drain_guard;

  logic [AXI_ADDR_WIDTH-1:0] bnd_off;
  logic [CW-1:0]             room;
  logic [CW-1:0]             chunk_w;
  logic [XFER_LEN_WIDTH-1:0] chunk;
  logic                      push;
  logic                      last_cmd;

  // Chunk is the smallest of what is left, the burst cap and the room up to the next boundary.
  always_comb begin
    bnd_off = cur_addr & AXI_ADDR_WIDTH'(BOUNDARY - 1);
    room    = (CW'(BOUNDARY) - CW'(bnd_off)) >> BPW_LOG;
    chunk_w = CW'(remaining);
    if (chunk_w > CW'(MAX_BURST))
      chunk_w = CW'(MAX_BURST);
    if (chunk_w > room)
      chunk_w = room;
    chunk = XFER_LEN_WIDTH'(chunk_w);
  end

  // dma_rd pushes unconditionally on config_valid, so it is gated by config_ready.
  assign push         = (state == ISSUE) && config_ready;
  assign last_cmd     = (remaining == chunk);
  assign config_valid = push;
  assign config_addr  = cur_addr;
  assign config_len   = CONFIG_LEN_WIDTH'(chunk);
  assign req_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign done         = (state == FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      cmd_count   <= '0;
      drain_guard <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cur_addr  <= req_addr & ~AXI_ADDR_WIDTH'(BPW - 1);
            remaining <= req_len;
            cmd_count <= '0;
            state     <= (req_len == '0) ? FINISH : ISSUE;
          end
        end
        ISSUE: begin
          if (push) begin
            cur_addr  <= cur_addr + (AXI_ADDR_WIDTH'(chunk) << BPW_LOG);
            remaining <= remaining - chunk;
            cmd_count <= cmd_count + XFER_LEN_WIDTH'(1);
            if (last_cmd) begin
              state       <= DRAIN;
              drain_guard <= 1'b1;
            end
          end
        end
        // The guard cycle lets the last push become visible in config_empty before it is trusted.
        DRAIN: begin
          if (drain_guard)
            drain_guard <= 1'b0;
          else if (config_empty)
            state <= FINISH;
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_rd_split.sv
// tb_dma_rd_split: directed tests for dma_rd_split against a queue-based command
// model, with a simple draining engine standing in for dma_rd.
module tb_dma_rd_split;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [19:0] req_len = '0;
  logic        config_valid;
  logic        config_ready = 1'b1;
  logic [31:0] config_addr;
  logic [8:0]  config_len;
  logic        config_empty;
  logic        busy;
  logic        done;
  logic [19:0] cmd_count;

  int checks = 0;
  int errors = 0;

  dma_rd_split #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .CONFIG_LEN_WIDTH(9),
    .XFER_LEN_WIDTH(20), .MAX_BURST(256), .BOUNDARY(4096)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .config_valid(config_valid), .config_ready(config_ready), .config_addr(config_addr),
    .config_len(config_len), .config_empty(config_empty),
    .busy(busy), .done(done), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  // Engine stand-in: buffers pushed words and retires up to 128 per idle cycle.
  int   pending = 0;
  logic instantEngine = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pending <= 0;
    else if (config_valid && !instantEngine)
      pending <= pending + int'(config_len);
    else if (pending > 128)
      pending <= pending - 128;
    else
      pending <= 0;
  end
  assign config_empty = (pending == 0);

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  typedef struct { logic [31:0] addr; logic [31:0] len; } cmd_t;
  cmd_t        expQ[$];
  int          cyc = 0;
  logic        busyExp = 1'b0;
  int          expDone = -1;
  int          waitFrom = -1;
  logic [19:0] cntExp = '0;
  int          logCount = 0;
  logic [31:0] logAddr [16];
  logic [31:0] logLen [16];
  int          logCycle [16];
  int          acceptCycle = -1;
  int          doneCycle = -1;
  int          busyCycles = 0;
  int          doneCount = 0;

  // Compare process: every cycle, the DUT outputs must match the command model.
  always @(negedge clk) begin
    logic        expValid;
    int unsigned a, r, room, c;
    cyc++;
    if (!rst_n) begin
      checkOutput("reset req_ready", req_ready, 1);
      checkOutput("reset config_valid", config_valid, 0);
      checkOutput("reset config_addr", config_addr, 0);
      checkOutput("reset config_len", config_len, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset cmd_count", cmd_count, 0);
      expQ.delete();
      busyExp = 1'b0; expDone = -1; waitFrom = -1; cntExp = '0; logCount = 0;
    end else begin
      expValid = busyExp && (expQ.size() > 0) && config_ready;
      checkOutput("config_valid", config_valid, expValid);
      if (busyExp && expQ.size() > 0) begin
        checkOutput("config_addr", config_addr, expQ[0].addr);
        checkOutput("config_len", config_len, expQ[0].len);
      end
      checkOutput("busy", busy, busyExp);
      checkOutput("req_ready", req_ready, !busyExp);
      checkOutput("cmd_count", cmd_count, cntExp);
      checkOutput("done", done, cyc == expDone);
      if (busyExp) busyCycles++;
      if (config_valid && logCount < 16) begin
        logAddr[logCount] = config_addr;
        logLen[logCount] = 32'(config_len);
        logCycle[logCount] = cyc;
        logCount++;
      end
      if (!busyExp && req_valid) begin
        acceptCycle = cyc; busyExp = 1'b1; cntExp = '0;
        logCount = 0; busyCycles = 0; doneCycle = -1; waitFrom = -1;
        a = req_addr & ~32'h3;
        r = 32'(req_len);
        expDone = (r == 0) ? cyc + 1 : -1;
        while (r > 0) begin
          room = (4096 - (a % 4096)) / 4;
          c = r;
          if (c > 256) c = 256;
          if (c > room) c = room;
          expQ.push_back('{addr: a, len: c});
          a = a + c * 4;
          r = r - c;
        end
      end else if (busyExp) begin
        if (expValid) begin
          void'(expQ.pop_front());
          cntExp++;
          if (expQ.size() == 0) waitFrom = cyc + 2;
        end
        if (waitFrom >= 0 && cyc >= waitFrom && expDone < 0 && config_empty)
          expDone = cyc + 1;
        if (cyc == expDone) begin
          busyExp = 1'b0; doneCycle = cyc; doneCount++;
          expDone = -1; waitFrom = -1;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [19:0] len);
    @(posedge clk); #2;
    req_valid = 1'b1; req_addr = addr; req_len = len;
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget);
    int n = 0;
    while (doneCount < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput("done within budget", doneCount >= target, 1);
  endtask

  task automatic waitFirstPush();
    int n = 0;
    while (logCount < 1 && n < 50) begin
      @(posedge clk);
      n++;
    end
    checkOutput("first push seen", logCount >= 1, 1);
  endtask

  initial begin
    int d0;
    int relCyc;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Three bursts back to back, last one trimmed; engine drains 600 words at 128/cycle.
    d0 = doneCount;
    applyStimulus(32'h1000, 20'd600);
    waitDone(d0 + 1, 200);
    checkOutput("A pushes", logCount, 3);
    checkOutput("A cmd0 addr", logAddr[0], 32'h1000);
    checkOutput("A cmd0 len", logLen[0], 256);
    checkOutput("A cmd1 addr", logAddr[1], 32'h1400);
    checkOutput("A cmd1 len", logLen[1], 256);
    checkOutput("A cmd2 addr", logAddr[2], 32'h1800);
    checkOutput("A cmd2 len", logLen[2], 88);
    checkOutput("A back to back", logCycle[2] - logCycle[0], 2);
    checkOutput("A done delay", doneCycle - logCycle[2], 7);
    checkOutput("A cmd_count", cmd_count, 3);

    d0 = doneCount;
    applyStimulus(32'h1FF0, 20'd10);
    waitDone(d0 + 1, 100);
    checkOutput("B pushes", logCount, 2);
    checkOutput("B cmd0 addr", logAddr[0], 32'h1FF0);
    checkOutput("B cmd0 len", logLen[0], 4);
    checkOutput("B cmd1 addr", logAddr[1], 32'h2000);
    checkOutput("B cmd1 len", logLen[1], 6);

    // Engine reports empty immediately, so only the guard cycle keeps done at p+3.
    instantEngine = 1'b1;
    d0 = doneCount;
    applyStimulus(32'h1003, 20'd2);
    waitDone(d0 + 1, 100);
    instantEngine = 1'b0;
    checkOutput("C pushes", logCount, 1);
    checkOutput("C cmd0 addr", logAddr[0], 32'h1000);
    checkOutput("C cmd0 len", logLen[0], 2);
    checkOutput("C done delay", doneCycle - logCycle[0], 3);

    d0 = doneCount;
    applyStimulus(32'h40, 20'd0);
    waitDone(d0 + 1, 50);
    checkOutput("D pushes", logCount, 0);
    checkOutput("D busy cycles", busyCycles, 1);
    checkOutput("D done delay", doneCycle - acceptCycle, 1);

    d0 = doneCount;
    applyStimulus(32'h1000, 20'd600);
    waitFirstPush();
    #2 config_ready = 1'b0;
    repeat (5) @(posedge clk);
    #2 config_ready = 1'b1;
    waitDone(d0 + 1, 200);
    checkOutput("E pushes", logCount, 3);
    checkOutput("E stall gap", logCycle[1] - logCycle[0], 6);
    checkOutput("E cmd1 addr", logAddr[1], 32'h1400);
    checkOutput("E cmd1 len", logLen[1], 256);
    checkOutput("E cmd2 addr", logAddr[2], 32'h1800);
    checkOutput("E cmd2 len", logLen[2], 88);
    checkOutput("E cmd_count", cmd_count, 3);

    // Reset after the first push, then a fresh request right at release.
    applyStimulus(32'h1000, 20'd600);
    waitFirstPush();
    #2 rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    relCyc = cyc;
    d0 = doneCount;
    req_valid = 1'b1; req_addr = 32'h1000; req_len = 20'd600;
    @(posedge clk); #2;
    req_valid = 1'b0;
    waitDone(d0 + 1, 200);
    checkOutput("F accept cycle", acceptCycle, relCyc + 1);
    checkOutput("F pushes", logCount, 3);
    checkOutput("F cmd0 addr", logAddr[0], 32'h1000);
    checkOutput("F cmd0 len", logLen[0], 256);
    checkOutput("F first push", logCycle[0] - acceptCycle, 1);
    checkOutput("F cmd_count", cmd_count, 3);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
